pol_par: RTL and testbench
==========================

# pol_par

Serial-to-parallel polynomial loader on the forward-NTT input path. It accepts the 256 16-bit coefficients of one Kyber polynomial, one per cycle, in natural index order. It then presents them to the 16-lane NTT datapath as 16 columns of 16 coefficients. Lane k of column j carries coefficient 16k + j, so it mirrors the layout the INTT output serializer uses.

## Interface
- Parameters: none. The geometry is fixed at 256 coefficients, 16 lanes and 16 columns.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data holds a coefficient
- in_data  in  16  coefficient value
- in_ready  out  1  loader accepts a coefficient this cycle
- out_ready  in  1  NTT consumer accepts the current column
- out_valid  out  1  NTT_0..NTT_15 hold a valid column
- out_col  out  4  index j of the presented column
- out_last  out  1  out_valid && out_col == 15
- NTT_0 … NTT_15  out  16 each  lane k = coefficient 16k + out_col

## Operation
- State machine: LOAD → EMIT → LOAD.
- Storage: 256×16 register buffer. The buffer is not reset.
- Write counter: wr_cnt, 8 bits.
- Column counter: col, 4 bits.
- LOAD state:
  - in_ready = 1.
  - On each cycle with in_valid && in_ready, store buf[wr_cnt] = in_data (after optional reduction) and increment wr_cnt.
  - Acceptance with wr_cnt == 255: wr_cnt wraps to 0, state → EMIT, col = 0, NTT_k ← buf[16k+0]. The coefficient accepted on that same edge is used as buf[255].
- EMIT state:
  - in_ready = 0; in_valid is ignored.
  - out_valid = 1.
  - On out_valid && out_ready with col < 15: col increments and NTT_k ← buf[16k + col + 1].
  - On out_valid && out_ready with col == 15: state → LOAD, col = 0, out_valid = 0.
- NTT_k, out_valid and out_col are registered. out_last is decoded combinationally from registered state. in_ready = (state == LOAD).
- Backpressure: while out_ready = 0 in EMIT, NTT_k, out_col and out_valid hold unchanged.
- Reset mid-operation: asynchronously returns the block to LOAD. A partially loaded or emitted polynomial is discarded, and the next accepted coefficient goes to index 0.

## Timing
- Reset values:
  - state = LOAD
  - wr_cnt = 0, col = 0
  - in_ready = 1
  - out_valid = 0, out_col = 0, out_last = 0
  - NTT_0..NTT_15 = 0
- Input throughput: 1 coefficient per cycle. 256 accepted coefficients take ≥256 cycles, and gaps in in_valid are allowed.
- Load-to-output latency: out_valid rises on the cycle after the edge that accepts coefficient 255.
- Output throughput: one column per cycle with out_ready held high. EMIT lasts ≥16 cycles.
- Back-to-back polynomials: in_ready returns to 1 on the cycle after the column-15 handshake. Minimum period is 256 + 16 = 272 cycles per polynomial.
- The input and output handshakes never overlap, because a single buffer is used.

## Configuration
- POL_PAR_MOD_REDUCE_EN defined:
  - Each accepted coefficient passes through one conditional subtraction before storage: if in_data ≥ 3329, store in_data − 3329, otherwise store in_data.
  - This is combinational and adds no latency.
  - Inputs ≥ 6658 are only partially reduced; correcting them is the producer's responsibility.
- POL_PAR_MOD_REDUCE_EN undefined: in_data is stored verbatim and no comparator is built.

## Test plan
- Ramp load and emit:
  - Stimulus: feed in_data = index (0..255) with in_valid held high and out_ready high.
  - Response: out_valid rises 1 cycle after the last accept. Column j shows NTT_k = 16k + j. out_last is high only at j = 15. in_ready returns 1 the cycle after that.
- Output backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles at col = 7.
  - Response: NTT_3 stays at 55 and out_col stays at 7 throughout. Emission resumes at col 8 after out_ready rises. No column is skipped or repeated.
- Input gaps and ignored input:
  - Stimulus: toggle in_valid every other cycle during load, then drive in_valid high during EMIT with in_data = 0xFFFF.
  - Response: the output ordering is identical to the ramp test, and 0xFFFF never appears.
- Reset mid-load:
  - Stimulus: assert reset after 100 accepts, then load a full ramp of value + 1000.
  - Response: outputs read to 0 during reset. NTT_0 at col 0 equals 1000, proving no stale offset.
- Modular reduction (macro defined):
  - Stimulus: load coefficient 0 = 3329, coefficient 1 = 3328, coefficient 16 = 5000.
  - Response: col 0 gives NTT_0 = 0 and NTT_1 = 1671. col 1 gives NTT_0 = 3328.
  - With the macro undefined, the same stimulus gives 3329, 5000 and 3328 respectively.

Source files
------------

// File: rtl/pol_par.sv
// Serial-to-parallel Kyber polynomial loader: 256 coefficients in, 16 columns of 16 lanes out.
// Optional POL_PAR_MOD_REDUCE_EN adds one conditional subtraction of q=3329 before storage.
module pol_par (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_col,
  output logic        out_last,
  output logic [15:0] NTT_0,
  output logic [15:0] NTT_1,
  output logic [15:0] NTT_2,
  output logic [15:0] NTT_3,
  output logic [15:0] NTT_4,
  output logic [15:0] NTT_5,
  output logic [15:0] NTT_6,
  output logic [15:0] NTT_7,
  output logic [15:0] NTT_8,
  output logic [15:0] NTT_9,
  output logic [15:0] NTT_10,
  output logic [15:0] NTT_11,
  output logic [15:0] NTT_12,
  output logic [15:0] NTT_13,
  output logic [15:0] NTT_14,
  output logic [15:0] NTT_15
);

  typedef enum logic {ST_LOAD, ST_EMIT} state_t;

  state_t      r_state;
  logic [7:0]  r_wr_cnt;
  logic [3:0]  r_col;
  logic        r_out_valid;
  logic [15:0] r_ntt [16];
  logic [15:0] r_buf [256];

  logic        w_acc;
  logic        w_adv;
  logic [15:0] w_wdata;
  logic [3:0]  w_rd_col;
  logic [15:0] w_col_data [16];

  assign w_acc = in_valid && (r_state == ST_LOAD);
  assign w_adv = r_out_valid && out_ready;

`ifdef POL_PAR_MOD_REDUCE_EN
  assign w_wdata = (in_data >= 16'd3329) ? (in_data - 16'd3329) : in_data;
`else
  assign w_wdata = in_data;
`endif

  // Column to present after this edge: 0 when leaving LOAD, next column in EMIT.
  assign w_rd_col = (r_state == ST_LOAD) ? '0 : (r_col + 4'd1);

  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      w_col_data[k] = r_buf[{k[3:0], w_rd_col}];
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_buf[r_wr_cnt] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_wr_cnt    <= '0;
      r_col       <= '0;
      r_out_valid <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
        r_ntt[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_acc) begin
            r_wr_cnt <= r_wr_cnt + 8'd1;
            // Column 0 never reads index 255, so the same-edge write is not needed yet.
            if (r_wr_cnt == 8'd255) begin
              r_state     <= ST_EMIT;
              r_col       <= '0;
              r_out_valid <= 1'b1;
              for (int unsigned k = 0; k < 16; k++) begin
                r_ntt[k] <= w_col_data[k];
              end
            end
          end
        end
        ST_EMIT: begin
          if (w_adv) begin
            if (r_col == 4'd15) begin
              r_state     <= ST_LOAD;
              r_col       <= '0;
              r_out_valid <= 1'b0;
            end else begin
              r_col <= r_col + 4'd1;
              for (int unsigned k = 0; k < 16; k++) begin
                r_ntt[k] <= w_col_data[k];
              end
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = r_out_valid;
  assign out_col   = r_col;
  assign out_last  = r_out_valid && (r_col == 4'd15);

  assign NTT_0  = r_ntt[0];
  assign NTT_1  = r_ntt[1];
  assign NTT_2  = r_ntt[2];
  assign NTT_3  = r_ntt[3];
  assign NTT_4  = r_ntt[4];
  assign NTT_5  = r_ntt[5];
  assign NTT_6  = r_ntt[6];
  assign NTT_7  = r_ntt[7];
  assign NTT_8  = r_ntt[8];
  assign NTT_9  = r_ntt[9];
  assign NTT_10 = r_ntt[10];
  assign NTT_11 = r_ntt[11];
  assign NTT_12 = r_ntt[12];
  assign NTT_13 = r_ntt[13];
  assign NTT_14 = r_ntt[14];
  assign NTT_15 = r_ntt[15];

endmodule

// File: tb/tb_pol_par.sv
// Self-checking bench for pol_par: reference model is a plain 256-entry coefficient array
// where column j, lane k is expected to equal coefficient 16k + j.
module tb_pol_par;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_col;
  logic        out_last;
  logic [15:0] ntt [16];

  int checks = 0;
  int errors = 0;

  logic [15:0] poly [256];
  logic [15:0] obs  [256];

  always #5 clk = ~clk;

  pol_par dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_col(out_col), .out_last(out_last),
    .NTT_0(ntt[0]),   .NTT_1(ntt[1]),   .NTT_2(ntt[2]),   .NTT_3(ntt[3]),
    .NTT_4(ntt[4]),   .NTT_5(ntt[5]),   .NTT_6(ntt[6]),   .NTT_7(ntt[7]),
    .NTT_8(ntt[8]),   .NTT_9(ntt[9]),   .NTT_10(ntt[10]), .NTT_11(ntt[11]),
    .NTT_12(ntt[12]), .NTT_13(ntt[13]), .NTT_14(ntt[14]), .NTT_15(ntt[15])
  );

  function automatic logic [15:0] ref_store(input logic [15:0] v);
`ifdef POL_PAR_MOD_REDUCE_EN
    return (v >= 16'd3329) ? v - 16'd3329 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 = continuous, 1 = alternate cycles, 2 = random gaps
  task automatic load_poly(input int gap_mode);
    int  i;
    int  cyc;
    bit  v;
    i = 0;
    cyc = 0;
    while (i < 256 && cyc < 3000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? poly[i] : 16'($urandom);
      checks++;
      if (in_ready !== 1'b1)
        $display("FAIL load_in_ready idx=%0d got=%b exp=1", i, in_ready);
      if (in_ready !== 1'b1) errors++;
      tick();
      cyc++;
      if (v) i++;
      if (i < 256) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL load_out_valid idx=%0d got=%b exp=0", i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    if (i < 256) begin
      checks++;
      errors++;
      $display("FAIL load_timeout accepted=%0d exp=256", i);
    end
    checks++;
    if (out_valid !== 1'b1 || out_col !== 4'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL emit_start got valid=%b col=%0d ready=%b exp valid=1 col=0 ready=0",
               out_valid, out_col, in_ready);
    end
  endtask

  task automatic emit_cols(input int stall_col, input int stall_len, input bit junk,
                           input bit rand_stall);
    int s;
    int bad_k;
    for (int j = 0; j < 16; j++) begin
      s = (j == stall_col) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      for (int t = 0; t <= s; t++) begin
        out_ready = (t == s);
        in_valid  = junk;
        in_data   = 16'hFFFF;
        bad_k = -1;
        for (int k = 0; k < 16; k++) begin
          if (ntt[k] !== ref_store(poly[16*k + j]) && bad_k < 0) bad_k = k;
          obs[16*k + j] = ntt[k];
        end
        checks++;
        if (out_valid !== 1'b1 || out_col !== 4'(j) || out_last !== (j == 15)) begin
          errors++;
          $display("FAIL emit_ctrl col=%0d got valid=%b col=%0d last=%b exp valid=1 col=%0d last=%b",
                   j, out_valid, out_col, out_last, j, (j == 15));
        end
        checks++;
        if (bad_k >= 0) begin
          errors++;
          $display("FAIL emit_lane col=%0d lane=%0d got=%0d exp=%0d", j, bad_k, ntt[bad_k],
                   ref_store(poly[16*bad_k + j]));
        end
        tick();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL emit_end got valid=%b ready=%b last=%b exp valid=0 ready=1 last=0",
               out_valid, in_ready, out_last);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_col !== 4'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b valid=%b col=%0d last=%b exp 1 0 0 0",
               in_ready, out_valid, out_col, out_last);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ntt[k] !== 16'd0) begin
        errors++;
        $display("FAIL reset_ntt lane=%0d got=%0d exp=0", k, ntt[k]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ramp;
    for (int i = 0; i < 256; i++) poly[i] = 16'(i);
    out_ready = 1'b1;
    load_poly(0);
    emit_cols(-1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 256; i++) poly[i] = 16'(i);
    load_poly(0);
    emit_cols(7, 5, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_and_ignored_input;
    for (int i = 0; i < 256; i++) poly[i] = 16'(i);
    load_poly(1);
    emit_cols(-1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_load;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_col !== 4'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl got ready=%b valid=%b col=%0d last=%b exp 1 0 0 0",
               in_ready, out_valid, out_col, out_last);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ntt[k] !== 16'd0) begin
        errors++;
        $display("FAIL midreset_ntt lane=%0d got=%0d exp=0", k, ntt[k]);
      end
    end
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) poly[i] = 16'(i + 1000);
    load_poly(0);
    emit_cols(-1, 0, 1'b0, 1'b0);
    checks++;
    if (obs[0] !== 16'd1000) begin
      errors++;
      $display("FAIL midreset_first got=%0d exp=1000", obs[0]);
    end
  endtask

  task automatic test_mod_reduce;
    logic [15:0] e0, e16;
    for (int i = 0; i < 256; i++) poly[i] = 16'($urandom_range(0, 3328));
    poly[0] = 16'd3329; poly[1] = 16'd3328; poly[16] = 16'd5000;
`ifdef POL_PAR_MOD_REDUCE_EN
    e0 = 16'd0; e16 = 16'd1671;
`else
    e0 = 16'd3329; e16 = 16'd5000;
`endif
    load_poly(0);
    emit_cols(-1, 0, 1'b0, 1'b0);
    checks++;
    if (obs[0] !== e0) begin
      errors++; $display("FAIL mod_c0_lane0 got=%0d exp=%0d", obs[0], e0);
    end
    checks++;
    if (obs[16] !== e16) begin
      errors++; $display("FAIL mod_c0_lane1 got=%0d exp=%0d", obs[16], e16);
    end
    checks++;
    if (obs[1] !== 16'd3328) begin
      errors++; $display("FAIL mod_c1_lane0 got=%0d exp=3328", obs[1]);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) poly[i] = 16'($urandom);
      load_poly(2);
      emit_cols(-1, 0, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 256; i++) poly[i] = 16'(255 - i);
    load_poly(0);
    emit_cols(-1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) poly[i] = 16'(i * 7);
    load_poly(0);
    emit_cols(-1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_gaps_and_ignored_input();
    test_reset_mid_load();
    test_mod_reduce();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
